// File: rtl/fetch_pair.sv
// Dual-issue fetch stage: requests instruction pairs, buffers them in a DEPTH-pair queue and
// presents the head pair to decode with valid/ready; stops at the first zero word, done when drained.
module fetch_pair #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter logic [31:0] NOP_WORD = 32'h13
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr_1,
    output logic [31:0] imem_addr_2,
    input  logic [31:0] imem_data_1,
    input  logic [31:0] imem_data_2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr_1,
    output logic [31:0] instr_2,
    output logic [31:0] pc_1,
    output logic        done
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] L_DEPTH = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] instr_1;
        logic [31:0] instr_2;
        logic [31:0] pc;
    } pair_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic          r_inflight;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    pair_t         r_mem [DEPTH];

    logic          w_pop;
    logic          w_push;
    logic          w_req;
    logic          w_resp;
    logic [CW:0]   w_credit_use;
    pair_t         w_push_dat;
    pair_t         w_head;

    assign w_pop  = (r_count != '0) && out_ready;
    assign w_resp = r_inflight && (r_state == S_FETCH);

    // Slots already committed (queued + returning) after this cycle's pop must leave room for one more pair.
    assign w_credit_use = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
    assign w_req        = rst_n && (r_state == S_FETCH) && (w_credit_use < L_DEPTH);

    always_comb begin
        w_state_nxt        = r_state;
        w_push             = 1'b0;
        w_push_dat.instr_1 = imem_data_1;
        w_push_dat.instr_2 = imem_data_2;
        w_push_dat.pc      = r_req_pc;
        case (r_state)
            S_FETCH: begin
                if (w_resp) begin
                    if (imem_data_1 == '0) begin
                        w_state_nxt = S_DRAIN;
                    end else if (imem_data_2 == '0) begin
                        w_push             = 1'b1;
                        w_push_dat.instr_2 = NOP_WORD;
                        w_state_nxt        = S_DRAIN;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (r_count == {{AW{1'b0}}, w_pop}) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= PC_RESET;
            r_req_pc   <= PC_RESET;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_req;
            if (w_req) begin
                r_pc     <= r_pc + 32'd8;
                r_req_pc <= r_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an empty queue masks the head outputs.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= w_push_dat;
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign out_valid   = (r_count != '0);
    assign instr_1     = out_valid ? w_head.instr_1 : 32'h0;
    assign instr_2     = out_valid ? w_head.instr_2 : 32'h0;
    assign pc_1        = out_valid ? w_head.pc : 32'h0;
    assign imem_req    = w_req;
    assign imem_addr_1 = r_pc;
    assign imem_addr_2 = r_pc + 32'd4;
    assign done        = (r_state == S_DONE);

endmodule
